abs_pipe: RTL and testbench
===========================

# abs_pipe

Pipelined, multi-lane absolute-value/negation unit for the radix-4 Booth multiplier datapath. It converts `LANES` signed operands per transaction to magnitude form and records each operand's sign, so the multiplier core can run unsigned and re-apply sign afterwards. Each transaction selects wrap-around abs, saturating abs, negate or pass-through. Two-way valid/ready handshakes allow full throughput under backpressure, and a saturating counter tracks overflow events.

## Interface
- `WIDTH`, 8: bits per lane operand (two's complement), ≥2
- `LANES`, 4: operands per transaction, ≥1
- `STAGES`, 2: pipeline register stages, 1..4
- `CNT_W`, 16: overflow counter width

Ports (`clk` rising edge; `rst` asynchronous, active-high):
- `clk`  in  1  clock
- `rst`  in  1  async active-high reset
- `in_valid`  in  1  input transaction valid
- `in_ready`  out  1  unit can accept input
- `in_data`  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- `in_mode`  in  2  `abs_mode_t`: 0 PASS, 1 ABS_WRAP, 2 ABS_SAT, 3 NEG
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  LANES*WIDTH  per-lane result
- `out_neg`  out  LANES  per-lane input sign bit (MSB of input)
- `out_ovf`  out  LANES  per-lane overflow flag
- `cnt_clr`  in  1  synchronous clear of `ovf_count`
- `ovf_count`  out  CNT_W  saturating count of overflowed lanes

## Operation
- MIN = 1 followed by WIDTH-1 zeros (0x80 at WIDTH=8); MAX = 0 followed by WIDTH-1 ones (0x7F).
- Per lane, evaluated combinationally before stage 1 register:
  - PASS: out = in, ovf = 0.
  - ABS_WRAP: out = in MSB ? (~in + 1) : in, truncated to WIDTH. ovf = (in == MIN), giving out = MIN.
  - ABS_SAT: as ABS_WRAP, but in == MIN gives out = MAX, ovf = 1.
  - NEG: out = ~in + 1, truncated. ovf = (in == MIN), giving out = MIN.
  - `out_neg` = input MSB in every mode.
  - Input 0: out 0, neg 0, ovf 0 in all modes.
- Pipeline: `STAGES` register slots, each with its own valid bit.
  - Slot k loads from slot k-1 (slot 1 loads from the input) when slot k is empty or slot k advances.
  - The last slot advances on `out_valid && out_ready`.
  - `in_ready` = slot 1 empty OR slot 1 advances; this is combinational from `out_ready` through the chain.
  - Input is accepted on `in_valid && in_ready`.
- No bubble insertion: sustained `in_valid` with `out_ready` = 1 gives one result per cycle.
- The output is held stable while `out_valid && !out_ready`.
- `ovf_count`:
  - On each output handshake it adds popcount(`out_ovf`).
  - It saturates at 2^CNT_W−1 and never wraps.
  - `cnt_clr` forces 0 on the next edge and takes priority over a same-cycle increment; that increment is discarded.

## Timing
- Latency is `STAGES` cycles from input handshake to `out_valid` with an unstalled pipe.
- Reset values:
  - all slot valids 0, so `out_valid` = 0 and `in_ready` = 1 after reset;
  - `out_data`, `out_neg`, `out_ovf` all 0;
  - `ovf_count` = 0.
- Reset asserted mid-operation drops all in-flight transactions; nothing is emitted after release.
- Data registers need no reset for function, but are reset to keep outputs defined.
- Full pipe with `out_ready` = 0: `in_ready` = 0, and any `in_valid` is held off with no loss.
- In the same cycle as an output handshake on a full pipe, a new input is accepted (`in_ready` = 1).

## Structure
- Package `abs_pkg` holds:
  - `typedef enum logic [1:0] abs_mode_t` {PASS, ABS_WRAP, ABS_SAT, NEG};
  - helper functions `min_val(WIDTH)` and `max_val(WIDTH)`.
- Sub-module `abs_lane`, instantiated `LANES` times in a generate loop:
  - parameter `WIDTH`;
  - inputs `data_in`, `mode`;
  - outputs `data_out`, `negative`, `ovf`;
  - purely combinational.
- The top level owns the slot registers, the handshake and the counter.

## Test plan
- **Modes, reset defaults** (WIDTH=8, LANES=4, STAGES=2), lanes {0x05, 0xFB, 0x00, 0x80}, `out_ready`=1:
  - ABS_WRAP → {0x05, 0x05, 0x00, 0x80}, neg={0,1,0,1}, ovf={0,0,0,1}; `out_valid` exactly 2 cycles after the handshake.
  - Same lanes ABS_SAT → lane 3 = 0x7F, ovf 1.
  - Same lanes NEG → {0xFB, 0x05, 0x00, 0x80}.
  - Same lanes PASS → unchanged, ovf all 0.
- **Throughput**: 100 back-to-back random transactions with `out_ready`=1 → 100 results on consecutive cycles, matching a reference model, in order.
- **Backpressure**: hold `out_ready`=0 until the pipe fills.
  - `in_ready` drops after 2 accepted transactions; output is stable.
  - Release `out_ready` → no loss, no duplication; `in_ready` rises in the same cycle.
  - Random `out_ready` toggling over 500 transactions → scoreboard clean.
- **Counter**:
  - 3 transactions, each with 2 lanes = 0x80 in ABS_SAT → `ovf_count`=6.
  - `cnt_clr` asserted in the same cycle as an overflow handshake → 0.
  - Force CNT_W=4 and 10 overflow transactions of 4 lanes → count sticks at 15.
- **Reset mid-flight**: assert `rst` asynchronously with 2 transactions in flight → `out_valid`=0, `out_data`=0 and `ovf_count`=0 immediately. After release, no stale outputs and `in_ready`=1.
- **Parameter sweep**: STAGES=1 and STAGES=4, WIDTH=16, LANES=1 → latency 1 and 4 respectively; 0x8000 in ABS_SAT gives 0x7FFF with ovf=1.

Source files
------------

// File: rtl/abs_pkg.sv
// Shared types and constants for the abs_pipe datapath: the per-transaction mode
// encoding and width-generic MIN/MAX helpers.
package abs_pkg;

  typedef enum logic [1:0] {
    PASS     = 2'd0,
    ABS_WRAP = 2'd1,
    ABS_SAT  = 2'd2,
    NEG      = 2'd3
  } abs_mode_t;

  // Results are 64 bits wide; callers keep the low `width` bits.
  function automatic logic [63:0] min_val(input int width);
    return 64'd1 << (width - 1);
  endfunction

  function automatic logic [63:0] max_val(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/abs_lane.sv
// One lane of abs_pipe: combinational abs/negate/pass of a two's complement operand,
// reporting the input sign and whether the most-negative value overflowed.
module abs_lane
  import abs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_in,
  input  abs_mode_t        mode,
  output logic [WIDTH-1:0] data_out,
  output logic             negative,
  output logic             ovf
);

  localparam logic [63:0]      MIN_L = min_val(WIDTH);
  localparam logic [63:0]      MAX_L = max_val(WIDTH);
  localparam logic [WIDTH-1:0] MIN_V = MIN_L[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_V = MAX_L[WIDTH-1:0];

  logic [WIDTH-1:0] neg_val;
  logic             is_min;

  always_comb begin
    // Negating MIN wraps back to MIN, which is the defined wrap-around result.
    neg_val  = ~data_in + WIDTH'(1);
    is_min   = (data_in == MIN_V);
    negative = data_in[WIDTH-1];
    data_out = data_in;
    ovf      = 1'b0;
    case (mode)
      PASS: begin
        data_out = data_in;
        ovf      = 1'b0;
      end
      ABS_WRAP: begin
        data_out = data_in[WIDTH-1] ? neg_val : data_in;
        ovf      = is_min;
      end
      ABS_SAT: begin
        data_out = is_min ? MAX_V : (data_in[WIDTH-1] ? neg_val : data_in);
        ovf      = is_min;
      end
      NEG: begin
        data_out = neg_val;
        ovf      = is_min;
      end
      default: begin
        data_out = data_in;
        ovf      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/abs_pipe.sv
// Multi-lane abs/negate unit: LANES abs_lane instances feed a STAGES-deep elastic
// pipeline with valid/ready handshakes and a saturating overflow-lane counter.
module abs_pipe
  import abs_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  abs_mode_t              in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_neg,
  output logic [LANES-1:0]       out_ovf,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       ovf_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and data stable until then, and ready may depend
  // combinationally on the downstream ready.

  localparam int DW = LANES * WIDTH;
  localparam int PW = $clog2(LANES + 1);
  localparam int SW = CNT_W + PW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DW-1:0]    lane_data;
  logic [LANES-1:0] lane_neg;
  logic [LANES-1:0] lane_ovf;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    abs_lane #(.WIDTH(WIDTH)) u_lane (
      .data_in (in_data[i*WIDTH +: WIDTH]),
      .mode    (in_mode),
      .data_out(lane_data[i*WIDTH +: WIDTH]),
      .negative(lane_neg[i]),
      .ovf     (lane_ovf[i])
    );
  end

  logic [STAGES-1:0] valid_q, valid_d, load;
  logic [DW-1:0]     data_q [STAGES];
  logic [DW-1:0]     data_d [STAGES];
  logic [LANES-1:0]  neg_q  [STAGES];
  logic [LANES-1:0]  neg_d  [STAGES];
  logic [LANES-1:0]  ovf_q  [STAGES];
  logic [LANES-1:0]  ovf_d  [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     pop;
  logic [SW-1:0]     sum;

  always_comb begin
    // A slot may load when it is empty or its contents move on this edge.
    load[STAGES-1] = !valid_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      load[k] = !valid_q[k] || load[k+1];
    end

    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      data_d[k]  = data_q[k];
      neg_d[k]   = neg_q[k];
      ovf_d[k]   = ovf_q[k];
    end

    if (load[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = lane_data;
        neg_d[0]  = lane_neg;
        ovf_d[0]  = lane_ovf;
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
          neg_d[k]  = neg_q[k-1];
          ovf_d[k]  = ovf_q[k-1];
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + PW'(ovf_q[STAGES-1][i]);
    end
    sum   = SW'(cnt_q) + SW'(pop);
    cnt_d = cnt_q;
    // Clear wins over a same-cycle increment, which is discarded.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid && out_ready) begin
      cnt_d = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        neg_q[k]  <= '0;
        ovf_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
        neg_q[k]  <= neg_d[k];
        ovf_q[k]  <= ovf_d[k];
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_neg   = neg_q[STAGES-1];
  assign out_ovf   = ovf_q[STAGES-1];
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_abs_pipe.sv
// Self-checking bench for abs_pipe: main 8x4x2 instance with a scoreboard, plus
// WIDTH=16 LANES=1 instances at STAGES=1 and STAGES=4 with a 4-bit counter.
module tb_abs_pipe;
  import abs_pkg::*;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int DW = W * L;
  localparam int EW = DW + 2 * L;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [DW-1:0]   in_data, out_data;
  abs_mode_t       in_mode;
  logic [L-1:0]    out_neg, out_ovf;
  logic [15:0]     ovf_count;

  logic            sm_valid, sm_out_ready, sm_clr;
  logic [15:0]     sm_data;
  abs_mode_t       sm_mode;
  logic            s1_in_ready, s1_valid, s1_neg, s1_ovf;
  logic [15:0]     s1_data;
  logic [3:0]      s1_count;
  logic            s4_in_ready, s4_valid, s4_neg, s4_ovf;
  logic [15:0]     s4_data;
  logic [3:0]      s4_count;

  abs_pipe #(.WIDTH(W), .LANES(L), .STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_neg(out_neg), .out_ovf(out_ovf), .cnt_clr(cnt_clr), .ovf_count(ovf_count)
  );

  abs_pipe #(.WIDTH(16), .LANES(1), .STAGES(1), .CNT_W(4)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(sm_valid), .in_ready(s1_in_ready), .in_data(sm_data),
    .in_mode(sm_mode), .out_valid(s1_valid), .out_ready(sm_out_ready), .out_data(s1_data),
    .out_neg(s1_neg), .out_ovf(s1_ovf), .cnt_clr(sm_clr), .ovf_count(s1_count)
  );

  abs_pipe #(.WIDTH(16), .LANES(1), .STAGES(4), .CNT_W(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_valid(sm_valid), .in_ready(s4_in_ready), .in_data(sm_data),
    .in_mode(sm_mode), .out_valid(s4_valid), .out_ready(sm_out_ready), .out_data(s4_data),
    .out_neg(s4_neg), .out_ovf(s4_ovf), .cnt_clr(sm_clr), .ovf_count(s4_count)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [9:0] ref_lane(input logic [7:0] x, input logic [1:0] m);
    int         v;
    logic [7:0] o;
    logic       ov;
    v  = int'($signed(x));
    o  = x;
    ov = 1'b0;
    case (m)
      2'd1: if (v < 0) begin o = 8'(-v); ov = (v == -128); end
      2'd2: if (v == -128) begin o = 8'h7F; ov = 1'b1; end
            else if (v < 0) o = 8'(-v);
      2'd3: begin o = 8'(-v); ov = (v == -128); end
      default: ;
    endcase
    return {ov, x[7], o};
  endfunction

  function automatic logic [EW-1:0] ref_txn(input logic [DW-1:0] d, input logic [1:0] m);
    logic [DW-1:0] od;
    logic [L-1:0]  on, oo;
    logic [9:0]    r;
    for (int i = 0; i < L; i++) begin
      r = ref_lane(d[i*W +: W], m);
      od[i*W +: W] = r[7:0];
      on[i] = r[8];
      oo[i] = r[9];
    end
    return {oo, on, od};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int cyc = 0, out_cnt = 0, mark = 0, first_out = 0, last_out = 0, model_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      check("ovf_count", 64'(ovf_count), 64'(model_cnt));
      mon_e = '0;
      if (out_valid && out_ready) begin
        check("out_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("out", 64'({out_ovf, out_neg, out_data}), 64'(mon_e));
        end
        if (out_cnt == mark) first_out = cyc;
        last_out = cyc;
        out_cnt++;
      end
      if (cnt_clr) model_cnt = 0;
      else if (out_valid && out_ready) begin
        model_cnt = model_cnt + $countones(mon_e[EW-1 -: L]);
        if (model_cnt > 65535) model_cnt = 65535;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_txn(in_data, in_mode));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] d, input abs_mode_t m);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic directed(input string tag, input logic [DW-1:0] d, input abs_mode_t m,
                          input logic [DW-1:0] ed, input logic [L-1:0] en,
                          input logic [L-1:0] eo);
    int lat = 1;
    send(d, m);
    in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd2);
    check({tag, "_data"}, 64'(out_data), 64'(ed));
    check({tag, "_neg"}, 64'(out_neg), 64'(en));
    check({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  localparam logic [DW-1:0] VEC  = {8'h80, 8'h00, 8'hFB, 8'h05};
  localparam logic [DW-1:0] OVF2 = {8'h80, 8'h12, 8'h80, 8'h00};
  logic [DW-1:0] t1, t2, t3;
  logic [EW-1:0] e1;
  bit done;
  int lat1, lat4;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_mode = PASS; out_ready = 1'b1; cnt_clr = 1'b0;
    sm_valid = 1'b0; sm_data = '0; sm_mode = PASS; sm_out_ready = 1'b1; sm_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_neg", 64'({out_neg, out_ovf}), 64'd0);
    check("rst_ovf_count", 64'(ovf_count), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Mode table on the main instance.
    directed("wrap", VEC, ABS_WRAP, 32'h8000_0505, 4'b1010, 4'b1000);
    directed("sat",  VEC, ABS_SAT,  32'h7F00_0505, 4'b1010, 4'b1000);
    directed("neg",  VEC, NEG,      32'h8000_05FB, 4'b1010, 4'b1000);
    directed("pass", VEC, PASS,     32'h8000_FB05, 4'b1010, 4'b0000);
    drain();

    // Throughput: back-to-back random transactions.
    mark = out_cnt;
    for (int i = 0; i < 100; i++) send(DW'($urandom), abs_mode_t'($urandom_range(0, 3)));
    drain();
    check("tput_count", 64'(out_cnt - mark), 64'd100);
    check("tput_span", 64'(last_out - first_out), 64'd99);

    // Backpressure: fill the pipe, hold, then release.
    mark = out_cnt;
    t1 = DW'($urandom); t2 = DW'($urandom); t3 = DW'($urandom);
    e1 = ref_txn(t1, 2'd1);
    out_ready = 1'b0;
    send(t1, ABS_WRAP);
    send(t2, NEG);
    in_data = t3;
    in_mode = ABS_SAT;
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    repeat (3) @(negedge clk);
    check("bp_hold_data", 64'(out_data), 64'(e1[DW-1:0]));
    check("bp_in_ready_still_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_release", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    drain();
    check("bp_count", 64'(out_cnt - mark), 64'd3);

    // Random backpressure with input gaps.
    mark = out_cnt;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 500; i++) begin
          send(DW'($urandom), abs_mode_t'($urandom_range(0, 3)));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("rand_bp_count", 64'(out_cnt - mark), 64'd500);

    // Counter: three transactions with two overflowing lanes each.
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("cnt_cleared", 64'(ovf_count), 64'd0);
    for (int i = 0; i < 3; i++) send(OVF2, ABS_SAT);
    drain();
    check("cnt_six", 64'(ovf_count), 64'd6);

    // Asynchronous reset with two transactions in flight.
    send(OVF2, ABS_SAT);
    send(VEC, NEG);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_ovf_count", 64'(ovf_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_out", 64'(out_valid), 64'd0);
    end
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Clear in the same cycle as an overflow handshake.
    send(OVF2, ABS_SAT);
    drain();
    check("cnt_two", 64'(ovf_count), 64'd2);
    out_ready = 1'b0;
    send(OVF2, ABS_SAT);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("cnt_clr_priority", 64'(ovf_count), 64'd0);
    drain();

    // Parameter sweep: latency and saturation on the 16-bit single-lane instances.
    sm_valid = 1'b1;
    sm_data  = 16'h8000;
    sm_mode  = ABS_SAT;
    @(posedge clk);
    #1;
    sm_valid = 1'b0;
    lat1 = 0;
    lat4 = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (s1_valid && lat1 == 0) begin
        lat1 = n;
        check("s1_data", 64'({s1_ovf, s1_neg, s1_data}), 64'h1_7FFF | (64'd1 << 17));
      end
      if (s4_valid && lat4 == 0) begin
        lat4 = n;
        check("s4_data", 64'({s4_ovf, s4_neg, s4_data}), 64'h1_7FFF | (64'd1 << 17));
      end
    end
    check("s1_latency", 64'(lat1), 64'd1);
    check("s4_latency", 64'(lat4), 64'd4);
    check("s1_count_one", 64'(s1_count), 64'd1);
    sm_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    sm_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("s1_count_sat", 64'(s1_count), 64'd15);
    check("s4_count_sat", 64'(s4_count), 64'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
